// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if
// Bundles the CPU-side request/response signals and the dmem-side bus of the
// data-cache controller.
//   master : environment view (CPU pipeline + dmem drive requests and mem_line)
//   slave  : controller view (dcache_ctrl)
// Signals:
//   cpu_read, cpu_write, cpu_address, cpu_write_data : CPU request
//   cpu_read_data, cpu_stall                         : CPU response
//   mem_address, mem_write, mem_write_data           : dmem request
//   mem_line                                         : dmem 16-word block, c0 at [31:0]
interface dcache_ctrl_if;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_address;
    logic [31:0]  cpu_write_data;
    logic [31:0]  cpu_read_data;
    logic         cpu_stall;
    logic [31:0]  mem_address;
    logic         mem_write;
    logic [31:0]  mem_write_data;
    logic [511:0] mem_line;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_write_data, mem_line,
        input  cpu_read_data, cpu_stall, mem_address, mem_write, mem_write_data
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_write_data, mem_line,
        output cpu_read_data, cpu_stall, mem_address, mem_write, mem_write_data
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data-cache controller
// between the CPU memory stage and dmem. Owns the tag, valid and line arrays,
// sequences whole-block fills on read misses and holds writes on the dmem bus
// for MEM_WAIT cycles while stalling the CPU.
// Parameters:
//   INDEX_BITS : cache holds 2^INDEX_BITS lines of 16 words
//   MEM_WAIT   : cycles dmem address/data are held per fill or write (>= 1)
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : dcache_ctrl_if.slave (CPU request/response + dmem bus)
//   hit_count  : read-hit counter  (only with DCACHE_STATS_EN)
//   miss_count : read-miss counter (only with DCACHE_STATS_EN)
// Optional feature macro: DCACHE_STATS_EN adds the hit/miss statistics.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int MEM_WAIT   = 4
) (
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.slave  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 26 - INDEX_BITS;
    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Storage
    logic [LINES-1:0]      valid_r;
    logic [TAG_W-1:0]      tag_mem [LINES];
    logic [15:0][31:0]     line_mem [LINES];

    // Control state
    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [31:0]           addr_r;
    logic [31:0]           wdata_r;
    logic                  mem_write_r;

    // Decode of the live CPU address and of the latched address
    logic [INDEX_BITS-1:0] cpu_index_s, lat_index_s;
    logic [TAG_W-1:0]      cpu_tag_s, lat_tag_s;
    logic [3:0]            cpu_off_s, lat_off_s;
    logic                  cpu_hit_s, lat_hit_s;

    // Next-state decisions
    logic                  stall_s;
    logic [31:0]           mem_addr_s;
    logic                  latch_read_s;
    logic                  latch_write_s;
    logic                  fill_s;
    logic                  line_upd_s;
    logic                  hit_inc_s;
    logic                  miss_inc_s;

    logic                  unused_s;

    assign cpu_off_s   = bus.cpu_address[5:2];
    assign cpu_index_s = bus.cpu_address[5+INDEX_BITS:6];
    assign cpu_tag_s   = bus.cpu_address[31:6+INDEX_BITS];
    assign cpu_hit_s   = valid_r[cpu_index_s] && (tag_mem[cpu_index_s] == cpu_tag_s);

    assign lat_off_s   = addr_r[5:2];
    assign lat_index_s = addr_r[5+INDEX_BITS:6];
    assign lat_tag_s   = addr_r[31:6+INDEX_BITS];
    assign lat_hit_s   = valid_r[lat_index_s] && (tag_mem[lat_index_s] == lat_tag_s);

    // Byte-lane bits carry no meaning for word accesses
    assign unused_s = ^{bus.cpu_address[1:0], addr_r[1:0]};

    assign bus.cpu_read_data  = line_mem[cpu_index_s][cpu_off_s];
    assign bus.cpu_stall      = stall_s;
    assign bus.mem_address    = mem_addr_s;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_write_data = wdata_r;

    // State register, wait counter and registered mem_write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            mem_write_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            // mem_write is high exactly while the controller sits in WRITE
            mem_write_r <= (state_s == ST_WRITE);
        end
    end

    // Next-state logic and combinational CPU/dmem outputs
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        stall_s       = 1'b0;
        mem_addr_s    = addr_r;
        latch_read_s  = 1'b0;
        latch_write_s = 1'b0;
        fill_s        = 1'b0;
        line_upd_s    = 1'b0;
        hit_inc_s     = 1'b0;
        miss_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_addr_s = bus.cpu_address;
                if (bus.cpu_write) begin
                    // Store wins over a simultaneous load
                    stall_s       = 1'b1;
                    latch_write_s = 1'b1;
                    cnt_s         = CNT_START;
                    state_s       = ST_WRITE;
                end else if (bus.cpu_read) begin
                    if (cpu_hit_s) begin
                        hit_inc_s = 1'b1;
                    end else begin
                        stall_s      = 1'b1;
                        latch_read_s = 1'b1;
                        miss_inc_s   = 1'b1;
                        cnt_s        = CNT_START;
                        state_s      = ST_FILL;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_FILL: begin
                stall_s = 1'b1;
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    fill_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (cnt_r != '0) begin
                    stall_s = 1'b1;
                    cnt_s   = cnt_r - CNT_W'(1);
                end else begin
                    // The CPU advances on this last cycle; the line update
                    // lands at the same edge so a following load sees it.
                    stall_s    = 1'b0;
                    line_upd_s = lat_hit_s;
                    state_s    = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Latched block/word address and store data
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (latch_write_s) begin
            addr_r  <= bus.cpu_address;
            wdata_r <= bus.cpu_write_data;
        end else if (latch_read_s) begin
            addr_r  <= {bus.cpu_address[31:6], 6'b0};
        end else begin
            addr_r  <= addr_r;
        end
    end

    // Valid bits: cleared on reset, set by a completed fill
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (fill_s) begin
            valid_r[lat_index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and line arrays; a reset edge suppresses any pending fill or update
    always_ff @(posedge clk) begin
        if (!rst && fill_s) begin
            tag_mem[lat_index_s]  <= lat_tag_s;
            line_mem[lat_index_s] <= bus.mem_line;
        end else if (!rst && line_upd_s) begin
            line_mem[lat_index_s][lat_off_s] <= wdata_r;
        end
    end

`ifdef DCACHE_STATS_EN
    // Read hit / miss statistics, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            hit_count  <= hit_count  + (hit_inc_s  ? 32'd1 : 32'd0);
            miss_count <= miss_count + (miss_inc_s ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
// Self-checking bench for dcache_ctrl (INDEX_BITS=4, MEM_WAIT=4). Contains a
// dmem model (word i = i unless written) and an abstract cache model: a
// reference memory the CPU should observe, plus per-index valid/tag used to
// predict hit/miss and stall lengths. Define DCACHE_STATS_EN to also check
// the statistics counters.
module tb_dcache_ctrl;

    localparam int MW = 4;

    logic clk;
    logic rst;
    dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl #(.INDEX_BITS(4), .MEM_WAIT(MW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // dmem model: 2048 words, word i holds i until written
    bit [2047:0] dm_wv;
    bit [31:0]   dm_wd [2048];

    function automatic logic [31:0] dm_word(input logic [10:0] w);
        return dm_wv[w] ? dm_wd[w] : {21'd0, w};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_write) begin
            dm_wv[bus.mem_address[12:2]] <= 1'b1;
            dm_wd[bus.mem_address[12:2]] <= bus.mem_write_data;
        end
    end

    always_comb begin
        bus.mem_line = '0;
        for (int c = 0; c < 16; c++) begin
            bus.mem_line[32*c +: 32] = dm_word({bus.mem_address[12:6], 4'(c)});
        end
    end

    // Abstract model
    logic [31:0] ref_mem [2048];
    bit   [15:0] m_valid;
    logic [21:0] m_tag [16];
    int          m_hits;
    int          m_misses;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
    int          mw_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cpu_read && !bus.cpu_write && !bus.cpu_stall)
                chk("read_data", bus.cpu_read_data, ref_mem[bus.cpu_address[12:2]]);
            if (bus.cpu_read && !bus.cpu_write && bus.cpu_stall)
                chk("fill_block_addr", {6'd0, bus.mem_address[31:6]}, {6'd0, bus.cpu_address[31:6]});
            if (bus.mem_write) begin
                mw_cycles++;
                chk("mem_address", bus.mem_address, exp_waddr);
                chk("mem_write_data", bus.mem_write_data, exp_wdata);
            end
        end
    end

    task automatic model_reset();
        m_valid  = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
        int  idx;
        bit  hit;
        bit  done;
        int  exp_stall;
        idx = int'(a[9:6]);
        hit = m_valid[idx] && (m_tag[idx] == a[31:10]);
        exp_stall = wr ? MW : (hit ? 0 : MW + 1);
        if (wr) begin
            exp_waddr = a;
            exp_wdata = wd;
            mw_cycles = 0;
        end
        @(posedge clk); #1;
        bus.cpu_read       = !wr;
        bus.cpu_write      = wr;
        bus.cpu_address    = a;
        bus.cpu_write_data = wd;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.cpu_stall) stalls++;
            else done = 1'b1;
        end
        rd = bus.cpu_read_data;
        chk("access_done", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        @(posedge clk); #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        if (wr) begin
            chk("mem_write_cycles", 32'(mw_cycles), 32'(MW));
            ref_mem[a[12:2]] = wd;
        end else if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:10];
            m_misses++;
            m_hits++;
        end else begin
            m_hits++;
        end
    endtask

    logic [31:0] rd;
    int          st;

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'(i);
        model_reset();
        rst                = 1'b1;
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b0;
        bus.cpu_address    = 32'd0;
        bus.cpu_write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
        chk("rst_mem_addr", bus.mem_address, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif

        // Cold read miss then neighbouring hit
        access(1'b0, 32'h40, 32'd0, rd, st);
        chk("s1_miss_stall", 32'(st), 32'd5);
        chk("s1_miss_data", rd, 32'd16);
        access(1'b0, 32'h44, 32'd0, rd, st);
        chk("s1_hit_stall", 32'(st), 32'd0);
        chk("s1_hit_data", rd, 32'd17);

        // One more hit, then statistics
        access(1'b0, 32'h40, 32'd0, rd, st);
        chk("s6_hit_data", rd, 32'd16);
`ifdef DCACHE_STATS_EN
        chk("s6_hit_count", hit_count, 32'd3);
        chk("s6_miss_count", miss_count, 32'd1);
        chk("s6_hit_model", hit_count, 32'(m_hits));
        chk("s6_miss_model", miss_count, 32'(m_misses));
`endif

        // Write hit goes through and updates the line
        access(1'b1, 32'h48, 32'hDEADBEEF, rd, st);
        chk("s2_write_stall", 32'(st), 32'd4);
        chk("s2_dmem_word18", dm_word(11'd18), 32'hDEADBEEF);
        access(1'b0, 32'h48, 32'd0, rd, st);
        chk("s2_read_stall", 32'(st), 32'd0);
        chk("s2_read_data", rd, 32'hDEADBEEF);

        // Write miss on a cold index: no allocation
        access(1'b1, 32'h1000, 32'd5, rd, st);
        chk("s3_write_stall", 32'(st), 32'd4);
        access(1'b0, 32'h1000, 32'd0, rd, st);
        chk("s3_read_stall", 32'(st), 32'd5);
        chk("s3_read_data", rd, 32'd5);

        // Conflict misses on index 1
        do_reset();
        access(1'b0, 32'h40, 32'd0, rd, st);
        chk("s4_a_stall", 32'(st), 32'd5);
        chk("s4_a_data", rd, 32'd16);
        access(1'b0, 32'h440, 32'd0, rd, st);
        chk("s4_b_stall", 32'(st), 32'd5);
        chk("s4_b_data", rd, 32'd272);
        access(1'b0, 32'h40, 32'd0, rd, st);
        chk("s4_c_stall", 32'(st), 32'd5);
        chk("s4_c_data", rd, 32'd16);

        // Reset during the second FILL cycle
        @(posedge clk); #1;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 32'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.cpu_read = 1'b0;
        model_reset();
        @(negedge clk);
        chk("s5_stall_after_rst", 32'(bus.cpu_stall), 32'd0);
        access(1'b0, 32'h80, 32'd0, rd, st);
        chk("s5_reread_stall", 32'(st), 32'd5);
        chk("s5_reread_data", rd, 32'd32);
`ifdef DCACHE_STATS_EN
        chk("end_hit_model", hit_count, 32'(m_hits));
        chk("end_miss_model", miss_count, 32'(m_misses));
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data-cache controller that sits between the CPU memory stage and `dmem`. It owns the tag, valid and line arrays. On a read miss it sequences a whole-block fill from `dmem`'s 16-word block read lines. Writes go through to `dmem` for the 30 ns memory delay, and the controller stalls the pipeline until each access completes.

## Interface

**Parameters**
- `INDEX_BITS`, default 4: number of index bits; the cache holds 2^INDEX_BITS lines of 16 words (64 B).
- `MEM_WAIT`, default 4: cycles the `dmem` address and data are held before a fill is captured or a write retires.
  - Minimum 1.
  - Must cover the 30 ns `dmem` delay at the system clock.

**Ports** (clock and reset first)
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_read` in 1: load request.
- `cpu_write` in 1: store request; wins if asserted together with `cpu_read`.
- `cpu_address` in 32: byte address; bits [1:0] are ignored.
- `cpu_write_data` in 32: store data.
- `cpu_read_data` out 32: load data, combinational from the line array.
- `cpu_stall` out 1: CPU must hold its request while this is high.
- `mem_address` out 32: address to `dmem`.
- `mem_write` out 1: write enable to `dmem`.
- `mem_write_data` out 32: write data to `dmem`.
- `mem_line` in 512: `dmem` block words c0..c15 concatenated, with c0 at [31:0].

## Operation

**Address split**
- Offset = [5:2].
- Index = [5+INDEX_BITS:6].
- Tag = [31:6+INDEX_BITS].
- Hit = `valid[index]` and `tag[index]` equal to the address tag.

**States:** IDLE, FILL, WRITE. A counter `cnt` runs from MEM_WAIT-1 down to 0.

**IDLE**
- `mem_address` = `cpu_address`.
- Read hit: `cpu_read_data` = line[index][offset], `cpu_stall` = 0, and the state stays IDLE.
- Read miss: `cpu_stall` = 1.
  - Latch the block address ({addr[31:6], 6'b0}).
  - Set `cnt` = MEM_WAIT-1 and go to FILL.
- Write (hit or miss): `cpu_stall` = 1.
  - Latch the address and data.
  - Set `cnt` = MEM_WAIT-1 and go to WRITE.
- No request: `cpu_stall` = 0.

**FILL**
- `mem_address` = latched block address; `cpu_stall` = 1.
- While `cnt` != 0, decrement `cnt`.
- When `cnt` == 0, at the next edge:
  - Write `mem_line` into line[index].
  - Set `tag[index]` and set `valid[index]`.
  - Go to IDLE.
- The next IDLE cycle hits and releases the CPU.

**WRITE**
- `mem_address` and `mem_write_data` = latched values; `mem_write` = 1 for every WRITE cycle.
- `cpu_stall` = 1 while `cnt` != 0 and 0 on the `cnt` == 0 cycle.
- At the edge leaving `cnt` == 0:
  - If the latched address hits, update line[index][offset] with the latched data.
  - Go to IDLE.
- A write miss never allocates and never changes tag or valid.

**Other rules**
- `cpu_read_data` outside an IDLE read hit is line[index][offset] of the current address and is don't-care to the CPU.
- Reset mid-FILL or mid-WRITE: the state returns to IDLE with no fill and no line update. A `dmem` word already written stays written.

## Timing

**Reset values**
- State IDLE, `cnt` 0, all valid bits 0.
- `mem_write` 0, `mem_write_data` 0, `cpu_stall` 0, latched address 0.
- Statistics counters 0.

**Latencies** (requests are seen in IDLE)
- Read hit: data in the same cycle, 0 stall cycles.
- Read miss: stall high for MEM_WAIT+1 cycles (the IDLE cycle plus MEM_WAIT FILL cycles). Data is valid on the following IDLE cycle.
- Write: stall high for MEM_WAIT cycles. The CPU advances at the end of the WRITE `cnt` == 0 cycle. `mem_write` is high for exactly MEM_WAIT cycles.

**Stability and ordering**
- `mem_address` and `mem_write_data` are stable throughout FILL and WRITE.
- Back-to-back write then read of the same word returns the new data (line update precedes the next IDLE).

## Configuration

`DCACHE_STATS_EN`
- **Defined:** adds 32-bit outputs `hit_count` and `miss_count`.
  - Each increments once per IDLE read-hit cycle and once per read miss accepted into FILL.
  - Writes are not counted.
  - Both wrap at 2^32.
  - Both clear on `rst`.
- **Undefined:** the ports and counters do not exist; all other behaviour is identical.

## Test plan

All scenarios use INDEX_BITS=4 and MEM_WAIT=4, with `dmem` preloaded so that word i = i.

1. Reset, then read 0x40: stall for 5 cycles, then `cpu_read_data` = 16. Then read 0x44: stall 0, data 17.
2. After scenario 1, write 0x48 = 0xDEADBEEF: stall for 4 cycles, `mem_write` high for 4 cycles, `dmem` word 18 = 0xDEADBEEF. Then read 0x48: stall 0, data 0xDEADBEEF.
3. Write 0x1000 = 5 on a cold index: no fill. A following read of 0x1000 misses (5 stall cycles) and returns 5.
4. Conflict: read 0x40, then 0x440, then 0x40 (same index 1, different tags): each access misses with 5 stall cycles and returns 16, 272, 16.
5. Assert `rst` during the 2nd FILL cycle of a read to 0x80: `cpu_stall` is 0 the cycle after reset. Re-reading 0x80 misses again.
6. With `DCACHE_STATS_EN` defined, run scenario 1 plus one more read of 0x40: `hit_count` = 3, `miss_count` = 1.
